// File: rtl/sonar_echo_timer_pkg.sv
// Shared definitions for the sonar echo timer: FSM state encoding and the
// default trigger/timeout constants (also used by the processor I/O decode).
package sonar_echo_timer_pkg;

    localparam int unsigned DEF_TRIG_CYCLES    = 500;      // 10 us @ 50 MHz
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1900000;  // 38 ms @ 50 MHz
    localparam int unsigned DEF_CNT_W          = 32;
    localparam int unsigned DEF_SYNC_STAGES    = 2;

    // Encodings match the legacy header values so software/decode stay compatible.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_TRIG = 3'd1,
        S_WAIT = 3'd2,
        S_MEAS = 3'd3,
        S_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/sonar_echo_timer_if.sv
// Processor-side handshake of the sonar echo timer.
//   start   : 1-cycle measurement request (processor -> timer)
//   ack     : result consumed (processor -> timer)
//   busy    : measurement in progress or result pending (timer -> processor)
//   valid   : result holds a good echo width
//   timeout : result is a timeout
//   width   : echo high time in clk cycles
interface sonar_echo_timer_if
    import sonar_echo_timer_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
);

    logic             start;
    logic             ack;
    logic             busy;
    logic             valid;
    logic             timeout;
    logic [CNT_W-1:0] width;

    modport master (
        output start, ack,
        input  busy, valid, timeout, width
    );

    modport slave (
        input  start, ack,
        output busy, valid, timeout, width
    );

endinterface

// File: rtl/sonar_echo_timer_sync_edge.sv
// Input synchronizer plus edge detector, reusable for any asynchronous pin.
//   clk, reset : clock and synchronous active-low reset
//   in         : raw asynchronous input
//   s          : synchronized level
//   rise/fall  : 1-cycle pulses on synchronized 0->1 / 1->0 transitions
// Both edges traverse the same path, so pulse widths measured between
// rise and fall are exact.
module sync_edge
    import sonar_echo_timer_pkg::*;
#(
    parameter int unsigned STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic s,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              s_dly_q, s_dly_d;

    always_comb begin
        sync_d  = {sync_q[STAGES-2:0], in};
        s_dly_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q  <= '0;
            s_dly_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            s_dly_q <= s_dly_d;
        end
    end

    assign s    = sync_q[STAGES-1];
    assign rise = s & ~s_dly_q;
    assign fall = ~s & s_dly_q;

endmodule

// File: rtl/sonar_echo_timer.sv
// Sonar echo timer: fires a trigger pulse, then times the returning echo
// pulse and presents its width to the processor through a start/result/ack
// handshake.
//   clk, reset : clock and synchronous active-low reset
//   host       : processor handshake (start, ack, busy, valid, timeout, width)
//   echo       : raw asynchronous echo pin
//   trig       : registered trigger pin
module sonar_echo_timer
    import sonar_echo_timer_pkg::*;
#(
    parameter int unsigned TRIG_CYCLES    = DEF_TRIG_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned CNT_W          = DEF_CNT_W,
    parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES
) (
    input  logic                clk,
    input  logic                reset,
    sonar_echo_timer_if.slave   host,
    input  logic                echo,
    output logic                trig
);

    localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic             trig_q, trig_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;

    logic             echo_rise;
    logic             echo_fall;
    logic             echo_level_unused;  // level not needed; only edges drive the FSM

    sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_echo_sync (
        .clk   (clk),
        .reset (reset),
        .in    (echo),
        .s     (echo_level_unused),
        .rise  (echo_rise),
        .fall  (echo_fall)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A rise in the last WAIT cycle beats the timeout, and
    // a fall coinciding with width reaching the limit is reported as valid.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (host.start)                state_d = S_TRIG;
            S_TRIG: if (cnt_q == TRIG_LAST)        state_d = S_WAIT;
            S_WAIT: begin
                if (echo_rise)                     state_d = S_MEAS;
                else if (cnt_q == TIMEOUT_LAST)    state_d = S_DONE;
            end
            S_MEAS: begin
                if (echo_fall || width_q == TIMEOUT_LAST)
                                                   state_d = S_DONE;
            end
            S_DONE: if (host.ack)                  state_d = S_IDLE;
            default:                               state_d = S_IDLE;
        endcase
    end

    // Output / datapath logic. trig and busy follow the next state so they
    // are registered alongside it; valid/timeout are set on DONE entry and
    // held until ack.
    always_comb begin
        cnt_d     = cnt_q;
        width_d   = width_q;
        trig_d    = (state_d == S_TRIG);
        busy_d    = (state_d != S_IDLE);
        valid_d   = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
            end
            S_TRIG: begin
                cnt_d = (cnt_q == TRIG_LAST) ? '0 : cnt_q + 1'b1;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (echo_rise || cnt_q == TIMEOUT_LAST) begin
                    width_d = '0;
                end
                timeout_d = !echo_rise && (cnt_q == TIMEOUT_LAST);
            end
            S_MEAS: begin
                // Counting on the fall cycle too makes width equal the high time.
                width_d   = width_q + 1'b1;
                valid_d   = echo_fall;
                timeout_d = !echo_fall && (width_q == TIMEOUT_LAST);
            end
            S_DONE: begin
                valid_d   = valid_q & ~host.ack;
                timeout_d = timeout_q & ~host.ack;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q     <= '0;
            width_q   <= '0;
            trig_q    <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            width_q   <= width_d;
            trig_q    <= trig_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign trig         = trig_q;
    assign host.busy    = busy_q;
    assign host.valid   = valid_q;
    assign host.timeout = timeout_q;
    assign host.width   = width_q;

endmodule

// File: tb/tb_sonar_echo_timer.sv
// Self-checking bench for sonar_echo_timer: echo waveforms described per
// transaction, expected result derived from pulse timing arithmetic.
module tb_sonar_echo_timer;

    localparam int TRIG = 10;
    localparam int TMO  = 2000;
    localparam int SYNC = 2;
    localparam int CW   = 32;
    localparam int LAT  = SYNC + 1;  // pin change to FSM reaction, in cycles

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic echo  = 1'b0;
    logic trig;

    sonar_echo_timer_if #(.CNT_W(CW)) bus ();

    sonar_echo_timer #(
        .TRIG_CYCLES    (TRIG),
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (CW),
        .SYNC_STAGES    (SYNC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .host  (bus),
        .echo  (echo),
        .trig  (trig)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int prev_width = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    typedef struct {
        bit prehigh;       // echo already high when trig falls
        int g1;            // prehigh level drops at this offset
        bit pulse;         // an echo pulse is driven
        int d;             // pulse start, cycles after trig falls
        int w;             // pulse high time
        int hold;          // cycles the result is left unacknowledged
        bit ack_start;     // assert start together with ack
        bit start_in_trig; // extra start while the trigger is high
        int reset_at;      // offset of a mid-run reset, -1 for none
    } scen_t;

    function automatic scen_t blank();
        scen_t s;
        s.prehigh = 0; s.g1 = 0; s.pulse = 0; s.d = 0; s.w = 0;
        s.hold = 0; s.ack_start = 0; s.start_in_trig = 0; s.reset_at = -1;
        return s;
    endfunction

    function automatic logic level(input scen_t s, input int j);
        if (s.prehigh && j < s.g1) return 1'b1;
        if (s.pulse && j >= s.d && j < s.d + s.w) return 1'b1;
        return 1'b0;
    endfunction

    // Outcome: offset (after trig fall) at which the result appears, flags, width.
    function automatic void model(input scen_t s, output int off, output bit v,
                                  output bit t, output int wid);
        if (s.pulse && s.d + LAT <= TMO) begin
            if (s.w > TMO) begin
                off = s.d + LAT + TMO; v = 0; t = 1; wid = TMO;
            end else begin
                off = s.d + LAT + s.w; v = 1; t = 0; wid = s.w;
            end
        end else begin
            off = TMO; v = 0; t = 1; wid = 0;
        end
    endfunction

    task automatic run_txn(input scen_t s);
        int  off_exp, w_exp, got_off, tcnt;
        bit  v_exp, t_exp;
        model(s, off_exp, v_exp, t_exp, w_exp);

        @(negedge clk);
        bus.start = 1'b1;
        if (s.prehigh) echo = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check_eq("busy_after_start", bus.busy, 1);
        check_eq("width_kept_at_start", bus.width, prev_width);

        tcnt = 0;
        for (int i = 0; i < 100 && trig; i++) begin
            tcnt++;
            bus.start = (s.start_in_trig && i == 3);
            @(negedge clk);
        end
        bus.start = 1'b0;
        check_eq("trig_len", tcnt, TRIG);

        got_off = -1;
        for (int j = 0; j < 2 * TMO + 100; j++) begin
            if (j > 0) @(negedge clk);
            bus.ack   = 1'b0;
            bus.start = 1'b0;
            if (s.reset_at == j) begin
                reset = 1'b0;
                echo  = 1'b0;
                @(negedge clk);
                reset = 1'b1;
                check_eq("rst_trig", trig, 0);
                check_eq("rst_busy", bus.busy, 0);
                check_eq("rst_valid", bus.valid, 0);
                check_eq("rst_timeout", bus.timeout, 0);
                check_eq("rst_width", bus.width, 0);
                repeat (5) @(negedge clk);
                check_eq("rst_idle_busy", bus.busy, 0);
                prev_width = 0;
                return;
            end
            if (bus.valid || bus.timeout) begin
                got_off = j;
                break;
            end
            echo      = level(s, j);
            bus.ack   = ($urandom_range(0, 49) == 0);
            bus.start = ($urandom_range(0, 49) == 0);
        end
        bus.ack   = 1'b0;
        bus.start = 1'b0;
        echo      = 1'b0;
        check_eq("done_offset", got_off, off_exp);
        check_eq("valid", bus.valid, v_exp);
        check_eq("timeout", bus.timeout, t_exp);
        check_eq("width", bus.width, w_exp);
        check_eq("busy_in_done", bus.busy, 1);

        repeat (s.hold) begin
            @(negedge clk);
            bus.start = ($urandom_range(0, 3) == 0);
        end
        @(negedge clk);
        bus.start = 1'b0;
        check_eq("held_valid", bus.valid, v_exp);
        check_eq("held_timeout", bus.timeout, t_exp);
        check_eq("held_width", bus.width, w_exp);

        bus.ack   = 1'b1;
        bus.start = s.ack_start;
        @(negedge clk);
        bus.ack   = 1'b0;
        bus.start = 1'b0;
        check_eq("ack_busy", bus.busy, 0);
        check_eq("ack_valid", bus.valid, 0);
        check_eq("ack_timeout", bus.timeout, 0);
        check_eq("ack_width_kept", bus.width, w_exp);
        @(negedge clk);
        check_eq("idle_trig", trig, 0);
        check_eq("idle_busy", bus.busy, 0);
        prev_width = w_exp;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        scen_t s;
        // Reset with active-looking inputs
        bus.start = 1'b1;
        bus.ack   = 1'b0;
        echo      = 1'b1;
        reset     = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("reset_trig", trig, 0);
        check_eq("reset_busy", bus.busy, 0);
        check_eq("reset_valid", bus.valid, 0);
        check_eq("reset_timeout", bus.timeout, 0);
        check_eq("reset_width", bus.width, 0);
        bus.start = 1'b0;
        echo      = 1'b0;
        reset     = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("post_reset_busy", bus.busy, 0);

        // Normal echo, second start during trigger, held 20 cycles
        s = blank(); s.pulse = 1; s.d = 50; s.w = 1000; s.hold = 20; s.start_in_trig = 1;
        run_txn(s);
        // No echo, start together with ack
        s = blank(); s.ack_start = 1; s.hold = 3;
        run_txn(s);
        // Echo high at trig fall, low 5 cycles, then too long
        s = blank(); s.prehigh = 1; s.g1 = 8; s.pulse = 1; s.d = 13; s.w = TMO + 100;
        run_txn(s);
        // Rise on the last wait cycle wins over timeout
        s = blank(); s.pulse = 1; s.d = TMO - LAT; s.w = 5;
        run_txn(s);
        // Rise one cycle too late
        s = blank(); s.pulse = 1; s.d = TMO - LAT + 1; s.w = 5;
        run_txn(s);
        // Width just below and just above the limit, and a 1-cycle pulse
        s = blank(); s.pulse = 1; s.d = 7; s.w = TMO - 1;
        run_txn(s);
        s = blank(); s.pulse = 1; s.d = 7; s.w = TMO + 1;
        run_txn(s);
        s = blank(); s.pulse = 1; s.d = 0; s.w = 1;
        run_txn(s);
        // Reset during measurement, then a normal run
        s = blank(); s.pulse = 1; s.d = 30; s.w = 1000; s.reset_at = 30 + LAT + 300;
        run_txn(s);
        s = blank(); s.pulse = 1; s.d = 20; s.w = 77;
        run_txn(s);

        for (int n = 0; n < 16; n++) begin
            int kind;
            s = blank();
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                s.pulse = 0;
            end else if (kind == 1) begin
                s.prehigh = 1;
                s.g1      = $urandom_range(0, 20);
                s.pulse   = 1;
                s.d       = s.g1 + 1 + $urandom_range(0, 10);
                s.w       = $urandom_range(1, 800);
            end else begin
                s.pulse = 1;
                s.d     = $urandom_range(0, 400);
                s.w     = $urandom_range(1, 1200);
            end
            s.hold          = $urandom_range(0, 15);
            s.ack_start     = $urandom_range(0, 1);
            s.start_in_trig = $urandom_range(0, 1);
            run_txn(s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
